echo_delay_ctrl: RTL and testbench
==================================

ECHO_DELAY_CTRL -- requirements
Module: echo_delay_ctrl

Interface
REQ-001 Parameters SHALL be: BITSIZE, default 24, sample and memory word width; ADDRLEN, default 14, delay-line address width (buffer depth 2^ADDRLEN words).
REQ-002 Ports SHALL be, in order:
  clk  in  1  single system clock, all logic on rising edge
  resetn  in  1  synchronous, active-low reset
  sample_stb  in  1  one-cycle pulse, new input sample present
  in_sample  in  BITSIZE  signed two's-complement input sample
  delay  in  ADDRLEN  echo delay in samples, sampled at sample_stb acceptance
  mix_shift  in  4  wet-path attenuation, arithmetic right shift
  fb_shift  in  4  feedback attenuation, arithmetic right shift
  enable  in  1  1 = echo active, 0 = bypass
  out_sample  out  BITSIZE  signed processed sample
  out_valid  out  1  one-cycle pulse, out_sample updated
  busy  out  1  controller not in IDLE
  overrun  out  1  sticky: a sample_stb was dropped
  mem_addr  out  ADDRLEN  memory address
  mem_wdata  out  BITSIZE  memory write data
  mem_rdata  in  BITSIZE  memory read data, valid the cycle after the address is presented
  mem_wren  out  1  memory write enable

Function
REQ-003 States SHALL be CLEAR, IDLE, RD, CAP, WR; one-hot or binary encoding is free.
REQ-004 CLEAR: mem_wren=1, mem_wdata=0, mem_addr = clear counter 0..2^ADDRLEN-1, one address per cycle; after address 2^ADDRLEN-1 -> IDLE with wptr=0.
REQ-005 IDLE: mem_wren=0; sample_stb=1 and enable=1 -> latch in_sample, delay, mix_shift, fb_shift; go RD.
REQ-006 IDLE with sample_stb=1 and enable=0 -> out_sample=in_sample, out_valid=1 the next cycle, no memory access, wptr unchanged.
REQ-007 RD: mem_addr = (wptr - delay_latched) mod 2^ADDRLEN, mem_wren=0; -> CAP.
REQ-008 CAP: register mem_rdata as dly; -> WR.
REQ-009 WR: mem_addr=wptr, mem_wren=1, mem_wdata = sat(in_latched + (dly >>> fb_shift)); out_sample <= sat(in_latched + (dly >>> mix_shift)); wptr <= wptr+1 mod 2^ADDRLEN; -> IDLE.
REQ-010 out_valid SHALL pulse for exactly one cycle, the cycle after WR; echo latency = 4 cycles from the sample_stb cycle to the out_valid cycle.
REQ-011 Additions SHALL be computed at BITSIZE+1 bits and saturated to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1]; shifts are arithmetic (sign-preserving).
REQ-012 delay=0 SHALL read address wptr, i.e. the sample written 2^ADDRLEN samples earlier (full-buffer delay); no special case.
REQ-013 sample_stb while busy=1 (any state other than IDLE, including CLEAR) SHALL be dropped, set overrun=1, and not disturb the current sequence.
REQ-014 Input changes to delay/shift/enable during RD/CAP/WR SHALL have no effect on the sequence in progress.
REQ-015 mem_addr and mem_wdata SHALL be 0 and mem_wren SHALL be 0 in IDLE.
REQ-016 busy SHALL be 1 in CLEAR, RD, CAP, WR and 0 in IDLE.

Reset
REQ-017 resetn=0 at a rising edge SHALL, from any state, force: state=CLEAR, clear counter=0, wptr=0, out_sample=0, out_valid=0, overrun=0, latched registers=0.
REQ-018 During resetn=0, mem_wren SHALL be 0; a reset mid-WR aborts the write, and the subsequent CLEAR sweep re-zeroes the entire buffer.
REQ-019 Minimum sustainable sample period after CLEAR SHALL be 4 cycles (stb in IDLE, RD, CAP, WR).

Verification
REQ-020 ADDRLEN=4: release reset -> 16 cycles of mem_wren=1, mem_wdata=0, addresses 0..15, busy=1, then busy=0.
REQ-021 ADDRLEN=4, delay=3, mix_shift=0, fb_shift=15, enable=1: impulse in_sample=1000 then zeros each 8 cycles -> out_sample 1000, 0, 0, 1000, 0...; memory writes at addresses 0,1,2,3... in order.
REQ-022 Saturation: stored delayed 0x7FFFF0 (BITSIZE=24), in_sample=0x000100, mix_shift=0 -> out_sample=0x7FFFFF; negative mirror -> 0x800000.
REQ-023 sample_stb asserted in the RD cycle following an accepted stb -> second stb dropped, overrun=1 and stays 1 until reset; exactly one out_valid pulse.
REQ-024 enable=0, in_sample=-5 -> out_sample=-5, out_valid one cycle later, mem_wren stays 0, wptr unchanged; delay=0 with ADDRLEN=4 returns the sample written 16 samples earlier.
REQ-025 resetn=0 asserted during WR -> no write that cycle, all outputs zero, full CLEAR sweep restarts at address 0.

Source files
------------

// File: rtl/echo_delay_ctrl.sv
// Echo/delay controller: sequences one external delay-line RAM read, then one write, per accepted sample.
// Wet output and feedback write-back are saturating sums of the input and the attenuated delayed sample.
module echo_delay_ctrl #(
  parameter int BITSIZE = 24,
  parameter int ADDRLEN = 14
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      sample_stb,
  input  logic signed [BITSIZE-1:0] in_sample,
  input  logic [ADDRLEN-1:0]        delay,
  input  logic [3:0]                mix_shift,
  input  logic [3:0]                fb_shift,
  input  logic                      enable,
  output logic signed [BITSIZE-1:0] out_sample,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic [ADDRLEN-1:0]        mem_addr,
  output logic [BITSIZE-1:0]        mem_wdata,
  input  logic [BITSIZE-1:0]        mem_rdata,
  output logic                      mem_wren
);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_CAP, S_WR} state_t;

  state_t                    state_q, state_d;
  logic [ADDRLEN-1:0]        clr_q, clr_d, wptr_q, wptr_d, dlen_q, dlen_d;
  logic signed [BITSIZE-1:0] in_q, in_d, dly_q, dly_d, out_q, out_d;
  logic [3:0]                mix_q, mix_d, fb_q, fb_d;
  logic                      vld_q, vld_d, ovr_q, ovr_d;
  logic signed [BITSIZE-1:0] wet, fbv;

  // Sum at BITSIZE+1 bits; differing top two bits means the result left the representable range.
  function automatic logic signed [BITSIZE-1:0] sat_add(input logic signed [BITSIZE-1:0] a,
                                                        input logic signed [BITSIZE-1:0] b);
    logic signed [BITSIZE:0] s;
    s = {a[BITSIZE-1], a} + {b[BITSIZE-1], b};
    if (s[BITSIZE] != s[BITSIZE-1])
      sat_add = s[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
    else
      sat_add = s[BITSIZE-1:0];
  endfunction

  assign wet = sat_add(in_q, dly_q >>> mix_q);
  assign fbv = sat_add(in_q, dly_q >>> fb_q);

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    wptr_d    = wptr_q;
    dlen_d    = dlen_q;
    in_d      = in_q;
    dly_d     = dly_q;
    out_d     = out_q;
    mix_d     = mix_q;
    fb_d      = fb_q;
    vld_d     = 1'b0;
    ovr_d     = ovr_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (sample_stb && state_q != S_IDLE) ovr_d = 1'b1;
    case (state_q)
      S_CLEAR: begin
        mem_wren = 1'b1;
        mem_addr = clr_q;
        clr_d    = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = S_IDLE;
          wptr_d  = '0;
        end
      end
      S_IDLE: begin
        if (sample_stb) begin
          if (enable) begin
            in_d    = in_sample;
            dlen_d  = delay;
            mix_d   = mix_shift;
            fb_d    = fb_shift;
            state_d = S_RD;
          end else begin
            out_d = in_sample;
            vld_d = 1'b1;
          end
        end
      end
      S_RD: begin
        mem_addr = wptr_q - dlen_q;
        state_d  = S_CAP;
      end
      S_CAP: begin
        dly_d   = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        mem_addr  = wptr_q;
        mem_wren  = 1'b1;
        mem_wdata = fbv;
        out_d     = wet;
        vld_d     = 1'b1;
        wptr_d    = wptr_q + 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
    // A write in flight while reset is held must not land in the RAM.
    if (!resetn) begin
      mem_wren  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_CLEAR;
      clr_q   <= '0;
      wptr_q  <= '0;
      dlen_q  <= '0;
      in_q    <= '0;
      dly_q   <= '0;
      out_q   <= '0;
      mix_q   <= '0;
      fb_q    <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      wptr_q  <= wptr_d;
      dlen_q  <= dlen_d;
      in_q    <= in_d;
      dly_q   <= dly_d;
      out_q   <= out_d;
      mix_q   <= mix_d;
      fb_q    <= fb_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_sample = out_q;
  assign out_valid  = vld_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl with a 16-word RAM: directed cases plus random samples against a
// sample-level echo model (circular buffer of saturated sums).
module tb_echo_delay_ctrl;
  localparam int BS = 24;
  localparam int AL = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           resetn, sample_stb, enable, mem_wren;
  logic [BS-1:0]  in_sample, mem_wdata, mem_rdata, out_sample;
  logic [AL-1:0]  delay, mem_addr;
  logic [3:0]     mix_shift, fb_shift;
  logic           out_valid, busy, overrun;

  echo_delay_ctrl #(.BITSIZE(BS), .ADDRLEN(AL)) dut (
    .clk(clk), .resetn(resetn), .sample_stb(sample_stb), .in_sample(in_sample),
    .delay(delay), .mix_shift(mix_shift), .fb_shift(fb_shift), .enable(enable),
    .out_sample(out_sample), .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wren(mem_wren)
  );

  always #5 clk = ~clk;

  logic [BS-1:0] tb_mem [DEPTH];
  int wren_cnt = 0;
  always @(posedge clk) begin
    if (mem_wren === 1'b1) begin
      tb_mem[mem_addr] <= mem_wdata;
      wren_cnt <= wren_cnt + 1;
    end
    mem_rdata <= tb_mem[mem_addr];
  end

  int checks = 0;
  int failures = 0;
  longint ref_buf [DEPTH];
  int ref_wptr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [BS-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sat(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic longint model_step(input longint s, input int d, input int mx,
                                        input int fb, input bit en);
    longint rd, o;
    if (!en) return s;
    rd = ref_buf[((ref_wptr - d) % DEPTH + DEPTH) % DEPTH];
    o = sat(s + (rd >>> mx));
    ref_buf[ref_wptr] = sat(s + (rd >>> fb));
    ref_wptr = (ref_wptr + 1) % DEPTH;
    return o;
  endfunction

  // One sample; optionally repeats the strobe during the read cycle. Inputs are scrambled after acceptance.
  task automatic send(input logic [BS-1:0] s, input int d, input int mx, input int fb,
                      input bit en, input bit dbl, output logic [BS-1:0] got);
    longint e;
    logic [BS-1:0] expv;
    int pulses, first;
    e = model_step(sx(s), d, mx, fb, en);
    expv = e[BS-1:0];
    pulses = 0;
    first = 0;
    got = '0;
    @(posedge clk); #1;
    sample_stb = 1'b1; in_sample = s; delay = 4'(d);
    mix_shift = 4'(mx); fb_shift = 4'(fb); enable = en;
    @(posedge clk); #1;
    sample_stb = dbl;
    in_sample = BS'($urandom); delay = 4'($urandom);
    mix_shift = 4'($urandom); fb_shift = 4'($urandom); enable = 1'($urandom);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = n;
          got = out_sample;
        end
      end
      if (n == 2) sample_stb = 1'b0;
    end
    sample_stb = 1'b0;
    chk("pulses", 64'(pulses), 64'd1);
    chk("latency", 64'(first), en ? 64'd4 : 64'd1);
    chk("out_sample", 64'(got), 64'(expv));
  endtask

  task automatic sweep();
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("clear_cycle", {busy, mem_wren, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'(i), 24'h0});
    end
    @(negedge clk);
    chk("clear_done_busy", 64'(busy), 64'd0);
    for (int i = 0; i < DEPTH; i++) ref_buf[i] = 0;
    ref_wptr = 0;
  endtask

  task automatic mem_cmp();
    longint v;
    for (int i = 0; i < DEPTH; i++) begin
      v = ref_buf[i];
      chk("mem_content", 64'(tb_mem[i]), 64'(v[BS-1:0]));
    end
  endtask

  initial begin
    logic [BS-1:0] got;
    int imp_exp [6];
    int w0;
    imp_exp = '{1000, 0, 0, 1000, 0, 0};
    resetn = 1'b0; sample_stb = 1'b0; in_sample = '0; delay = '0;
    mix_shift = '0; fb_shift = '0; enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {out_sample, out_valid, overrun, mem_wren, busy}, {24'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    sweep();

    // Impulse through a 3-sample delay, feedback fully attenuated.
    for (int i = 0; i < 6; i++) begin
      send((i == 0) ? 24'd1000 : 24'd0, 3, 0, 15, 1'b1, 1'b0, got);
      chk("impulse", 64'(got), 64'(BS'(imp_exp[i])));
    end
    mem_cmp();

    chk("overrun_clear", 64'(overrun), 64'd0);
    w0 = wren_cnt;
    send(-24'sd5, 2, 0, 0, 1'b0, 1'b0, got);
    chk("bypass_val", 64'(got), 64'(24'hFFFFFB));
    chk("bypass_no_write", 64'(wren_cnt), 64'(w0));

    send(24'h7FFFF0, 1, 0, 0, 1'b1, 1'b0, got);
    send(24'h000100, 1, 0, 15, 1'b1, 1'b0, got);
    chk("sat_pos", 64'(got), 64'(24'h7FFFFF));
    send(24'h800010, 1, 15, 15, 1'b1, 1'b0, got);
    send(24'hFFFF00, 1, 0, 15, 1'b1, 1'b0, got);
    chk("sat_neg", 64'(got), 64'(24'h800000));

    send(24'd4242, 5, 1, 2, 1'b1, 1'b1, got);
    chk("overrun_set", 64'(overrun), 64'd1);

    for (int k = 0; k < 40; k++) begin
      bit en, dbl;
      en = ($urandom_range(0, 4) != 0);
      dbl = en && ($urandom_range(0, 5) == 0);
      send(BS'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           en, dbl, got);
    end
    chk("overrun_sticky", 64'(overrun), 64'd1);
    mem_cmp();

    // Reset asserted in the write cycle: no write, outputs cleared, full sweep again.
    @(posedge clk); #1;
    sample_stb = 1'b1; in_sample = 24'd1234; delay = 4'd2; mix_shift = '0; fb_shift = '0; enable = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    w0 = wren_cnt;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_wr_bus", {mem_wren, mem_addr, mem_wdata}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wr_outs", {out_sample, out_valid, overrun, busy, mem_wren}, {24'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("rst_wr_no_write", 64'(wren_cnt), 64'(w0));
    sweep();

    // delay=0 reads the sample written one full buffer earlier.
    for (int i = 0; i < DEPTH; i++) send(BS'((i + 1) * 1000), 0, 0, 0, 1'b1, 1'b0, got);
    send(24'd0, 0, 0, 0, 1'b1, 1'b0, got);
    chk("delay0_full", 64'(got), 64'(24'd1000));
    mem_cmp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
